// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and helpers for the multi-cycle wide add/sub sequencer.
package add_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow: operands agree in sign but the result sign differs.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        calc_ovf = (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_seq_ctrl_add8.sv
// Parameterised N-bit ripple-carry adder, shared across all chunks of an operation.
module add8 #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] carry_s;

    // Bit-serial carry chain, LSB first.
    always_comb begin
        carry_s    = '0;
        sum_o      = '0;
        carry_s[0] = cin_i;
        for (int i = 0; i < int'(N); i++) begin
            sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
            carry_s[i + 1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry_s[N];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle W-bit adder/subtractor: one N-bit adder time-shared over CHUNKS slices,
// LSB chunk first, with valid/ready handshakes on operand and result sides.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*CHUNKS-1:0] a,
    input  logic [N*CHUNKS-1:0] b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*CHUNKS-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int unsigned W  = N * CHUNKS;
    localparam int unsigned CW = $clog2(CHUNKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHUNKS - 1);

    state_e        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  acc_q;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic          a_msb_q;
    logic          b_msb_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;
    logic          out_valid_q;
    logic          in_ready_q;

    logic [N-1:0]  chunk_sum_s;
    logic          chunk_cout_s;
    logic [W-1:0]  b_in_s;
    logic [W-1:0]  acc_d;
    logic [W-1:0]  a_d;
    logic [W-1:0]  b_d;

    add8 #(.N(N)) u_add (
        .a_i    (a_q[N-1:0]),
        .b_i    (b_q[N-1:0]),
        .cin_i  (carry_q),
        .sum_o  (chunk_sum_s),
        .cout_o (chunk_cout_s)
    );

    // Operand conditioning and per-chunk shift values; shifts written to stay legal for CHUNKS=1.
    always_comb begin
        b_in_s = b;
        if (sub) begin
            b_in_s = ~b;
        end else begin
            b_in_s = b;
        end
        acc_d = (acc_q >> N) | (W'(chunk_sum_s) << (W - N));
        a_d   = a_q >> N;
        b_d   = b_q >> N;
    end

    // Sequencer FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= ST_RUN;
                        a_q        <= a;
                        b_q        <= b_in_s;
                        carry_q    <= sub;
                        cnt_q      <= '0;
                        a_msb_q    <= a[W-1];
                        b_msb_q    <= b_in_s[W-1];
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    a_q     <= a_d;
                    b_q     <= b_d;
                    carry_q <= chunk_cout_s;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_DONE;
                        sum_q       <= acc_d;
                        cout_q      <= chunk_cout_s;
                        ovf_q       <= calc_ovf(a_msb_q, b_msb_q, chunk_sum_s[N-1]);
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (N=8, CHUNKS=4): vector table plus scoreboard.
module tb_add_seq_ctrl;

    localparam int N      = 8;
    localparam int CHUNKS = 4;
    localparam int W      = N * CHUNKS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           hold;
        bit           scramble;
    } vec_t;

    exp_t sb[$];
    int   n_assert;
    int   n_fail;

    add_seq_ctrl #(.N(N), .CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference: unsigned compare for carry, 64-bit signed math for overflow.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        exp_t   e;
        logic [W:0] u;
        longint sr;
        if (s) begin
            u      = {1'b0, av} - {1'b0, bv};
            e.cout = (av >= bv);
            sr     = longint'($signed(av)) - longint'($signed(bv));
        end else begin
            u      = {1'b0, av} + {1'b0, bv};
            e.cout = u[W];
            sr     = longint'($signed(av)) + longint'($signed(bv));
        end
        e.sum = u[W-1:0];
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                          input exp_t e, input int hold, input bit scramble);
        int   lat;
        int   k;
        exp_t got;
        logic [W-1:0] held;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_op", {63'd0, in_ready}, 64'd1);
        a        = av;
        b        = bv;
        sub      = s;
        in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a        = $urandom;
                b        = $urandom;
                sub      = 1'($urandom_range(1));
                in_valid = 1'($urandom_range(1));
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(lat), 64'(CHUNKS));
        if (!out_valid) begin
            void'(sb.pop_front());
            return;
        end
        held = sum;
        for (int h = 0; h < hold; h++) begin
            a        = $urandom;
            b        = $urandom;
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_sum", {32'd0, sum}, {32'd0, held});
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        got = sb.pop_front();
        chk("sum", {32'd0, sum}, {32'd0, got.sum});
        chk("cout", {63'd0, cout}, {63'd0, got.cout});
        chk("ovf", {63'd0, ovf}, {63'd0, got.ovf});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
        chk("in_ready_return", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        vec_t vt[$];
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           seen;

        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        vt.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, 1'b0});
        vt.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0});
        vt.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0});
        vt.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0});
        vt.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 3, 1'b0});
        vt.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0, 1'b1});
        vt.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1, 1'b1});
        vt.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0});
        vt.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0});

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);

        // Table-driven vectors
        for (int i = 0; i < vt.size(); i++) begin
            e.sum  = vt[i].sum;
            e.cout = vt[i].cout;
            e.ovf  = vt[i].ovf;
            run_op(vt[i].a, vt[i].b, vt[i].sub, e, vt[i].hold, vt[i].scramble);
        end

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(1));
            run_op(ra, rb, rs, model(ra, rb, rs), int'($urandom_range(2)), 1'($urandom_range(1)));
        end

        // Reset pulse after the 2nd RUN edge aborts the operation
        a        = 32'hDEAD_BEEF;
        b        = 32'h0BAD_F00D;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_out_valid", 64'(seen), 64'd0);
        chk("abort_sum_cleared", {32'd0, sum}, 64'd0);
        e.sum  = 32'h2345_6789;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, e, 0, 1'b0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
